// File: rtl/fifo_wr_arbiter.sv
//------------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Purpose:
//   Shares the single write port of one fifo among N_REQ independent
//   producers. Arbitration is round-robin with packet lock: once a producer
//   is granted, it keeps the port until it presents its last beat, or until
//   it has moved MAX_BURST beats, whichever comes first. After either event
//   the arbiter returns to IDLE. Each arbitration costs one cycle.
//
// Parameters:
//   WIDTH      data width per beat (must match the fifo width)
//   N_REQ      number of requesters (>= 2)
//   MAX_BURST  maximum beats per grant before a forced re-arbitration (>= 1)
//   ID_WIDTH   width of the grant index
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst         asynchronous active-low reset (0 = reset)
//   req_valid   per-requester beat valid
//   req_last    per-requester last beat of packet (qualified by valid)
//   req_data    requester i data at [i*WIDTH +: WIDTH]
//   req_ready   per-requester accept; a beat moves when valid & ready
//   fifo_wr_en  write enable to the fifo
//   fifo_din    write data to the fifo
//   fifo_full   full flag from the fifo
//   busy        high while a grant is held
//   grant_id    index of the granted requester, meaningful while busy
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module fifo_wr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 16,
  parameter int ID_WIDTH  = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ-1:0]         req_last,
  input  logic [N_REQ*WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     fifo_wr_en,
  output logic [WIDTH-1:0]         fifo_din,
  input  logic                     fifo_full,
  output logic                     busy,
  output logic [ID_WIDTH-1:0]      grant_id
);

  localparam int CNT_WIDTH = $clog2(MAX_BURST + 1);

  // Value at which the current beat is the final one allowed in this grant.
  localparam logic [CNT_WIDTH-1:0] BURST_LAST = CNT_WIDTH'(MAX_BURST - 1);

  // Reset value of last_id makes requester 0 the first one searched.
  localparam logic [ID_WIDTH-1:0] LAST_ID_RST = ID_WIDTH'(N_REQ - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ID_WIDTH-1:0]   last_id;
  logic [ID_WIDTH-1:0]   last_id_nxt;
  logic [ID_WIDTH-1:0]   grant_id_nxt;
  logic [CNT_WIDTH-1:0]  beat_cnt;
  logic [CNT_WIDTH-1:0]  beat_cnt_nxt;

  logic                  arb_found;
  logic [ID_WIDTH-1:0]   arb_id;
  logic [ID_WIDTH-1:0]   cand;
  logic                  burst_end;

  logic [WIDTH-1:0]      data_arr [N_REQ];

  // Unpack the flat data bus so the granted beat can be selected by index.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
  end

  // Round-robin search: start one past the previous winner and wrap, so the
  // most recently served requester is considered last.
  always_comb begin
    arb_found = 1'b0;
    arb_id    = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ID_WIDTH'((int'(last_id) + k) % N_REQ);
      if (!arb_found && req_valid[cand]) begin
        arb_found = 1'b1;
        arb_id    = cand;
      end
    end
  end

  // Write-side outputs. Only the granted requester can see ready, and a
  // write happens only when that requester has a beat and the fifo has room.
  // Ready does not depend on valid, so a granted requester that pauses still
  // sees ready high while the fifo has space.
  always_comb begin
    req_ready  = '0;
    fifo_wr_en = 1'b0;
    fifo_din   = '0;
    busy       = 1'b0;
    if (state == GRANT) begin
      busy                = 1'b1;
      req_ready[grant_id] = ~fifo_full;
      fifo_wr_en          = req_valid[grant_id] & ~fifo_full;
      fifo_din            = data_arr[grant_id];
    end
  end

  // The grant ends on the packet's last beat or on the final beat allowed
  // in one burst; a cut packet continues on a later grant.
  assign burst_end = req_last[grant_id] | (beat_cnt == BURST_LAST);

  // Next-state logic. While granted and stalled (no valid or fifo full),
  // everything holds, which gives the packet lock and the lossless stall.
  always_comb begin
    state_nxt    = state;
    last_id_nxt  = last_id;
    grant_id_nxt = grant_id;
    beat_cnt_nxt = beat_cnt;
    unique case (state)
      IDLE: begin
        if (arb_found) begin
          grant_id_nxt = arb_id;
          beat_cnt_nxt = '0;
          state_nxt    = GRANT;
        end
      end
      GRANT: begin
        if (fifo_wr_en) begin
          if (burst_end) begin
            last_id_nxt  = grant_id;
            beat_cnt_nxt = '0;
            state_nxt    = IDLE;
          end else begin
            beat_cnt_nxt = beat_cnt + CNT_WIDTH'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State registers. Reset returns to IDLE at once; beats already handed to
  // the fifo before reset are not undone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      last_id  <= LAST_ID_RST;
      grant_id <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      last_id  <= last_id_nxt;
      grant_id <= grant_id_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
//------------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Directed testbench for fifo_wr_arbiter (WIDTH=8, N_REQ=4, MAX_BURST=16).
// Each requester is fed from a queue of beats which advances only when the
// beat is accepted. Inputs change just after the falling edge and outputs are
// sampled 1 ns later, well away from the rising edge.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_fifo_wr_arbiter;

  localparam int W  = 8;
  localparam int NR = 4;
  localparam int MB = 16;
  localparam int IW = 2;

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_last;
  logic [NR*W-1:0]   req_data;
  logic [NR-1:0]     req_ready;
  logic              fifo_wr_en;
  logic [W-1:0]      fifo_din;
  logic              fifo_full;
  logic              busy;
  logic [IW-1:0]     grant_id;

  fifo_wr_arbiter #(
    .WIDTH     (W),
    .N_REQ     (NR),
    .MAX_BURST (MB),
    .ID_WIDTH  (IW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .fifo_full  (fifo_full),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  logic [W-1:0]  q_data [NR][$];
  logic          q_last [NR][$];
  logic [NR-1:0] pop;
  logic [NR-1:0] mask;
  logic          hold_full;
  logic [W-1:0]  log_data [$];
  logic [IW-1:0] log_src  [$];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Empty all producer queues and logs and drive idle inputs.
  task automatic clear_all();
    for (int i = 0; i < NR; i++) begin
      q_data[i].delete();
      q_last[i].delete();
    end
    log_data.delete();
    log_src.delete();
    pop       = '0;
    mask      = '0;
    hold_full = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;
  endtask

  task automatic push_beat(input int r, input logic [W-1:0] d, input logic l);
    q_data[r].push_back(d);
    q_last[r].push_back(l);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    clear_all();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One cycle: retire beats accepted at the last rising edge, present the
  // queue heads, then let the combinational outputs settle and log writes.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      if (pop[i] && q_data[i].size() > 0) begin
        q_data[i].delete(0);
        q_last[i].delete(0);
      end
      pop[i] = 1'b0;
    end
    fifo_full = hold_full;
    for (int i = 0; i < NR; i++) begin
      if (q_data[i].size() > 0) begin
        req_valid[i]      = ~mask[i];
        req_data[i*W +: W] = q_data[i][0];
        req_last[i]       = q_last[i][0];
      end else begin
        req_valid[i]      = 1'b0;
        req_data[i*W +: W] = '0;
        req_last[i]       = 1'b0;
      end
    end
    #1;
    for (int i = 0; i < NR; i++) begin
      if (req_valid[i] && req_ready[i]) pop[i] = 1'b1;
    end
    if (fifo_wr_en) begin
      log_data.push_back(fifo_din);
      log_src.push_back(grant_id);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_all();
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else passed++;
    checks++; if (fifo_wr_en !== 1'b0) $display("[TB] FAIL reset_wr_en: got %b want 0", fifo_wr_en); else passed++;
    checks++; if (req_ready !== 4'b0000) $display("[TB] FAIL reset_ready: got %b want 0000", req_ready); else passed++;
    checks++; if (fifo_din !== 8'h00) $display("[TB] FAIL reset_din: got %h want 00", fifo_din); else passed++;
    checks++; if (grant_id !== 2'd0) $display("[TB] FAIL reset_grant_id: got %0d want 0", grant_id); else passed++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single_packet();
    logic [W-1:0] exp_d [3];
    exp_d[0] = 8'hAA; exp_d[1] = 8'hBB; exp_d[2] = 8'hCC;
    apply_reset();
    push_beat(0, 8'hAA, 1'b0);
    push_beat(0, 8'hBB, 1'b0);
    push_beat(0, 8'hCC, 1'b1);
    step();
    checks++; if (busy !== 1'b0) $display("[TB] FAIL single_arb_busy: got %b want 0", busy); else passed++;
    checks++; if (fifo_wr_en !== 1'b0) $display("[TB] FAIL single_arb_wr_en: got %b want 0", fifo_wr_en); else passed++;
    checks++; if (req_ready !== 4'b0000) $display("[TB] FAIL single_arb_ready: got %b want 0000", req_ready); else passed++;
    for (int b = 0; b < 3; b++) begin
      step();
      checks++; if (fifo_wr_en !== 1'b1) $display("[TB] FAIL single_wr_en beat %0d: got %b want 1", b, fifo_wr_en); else passed++;
      checks++; if (fifo_din !== exp_d[b]) $display("[TB] FAIL single_din beat %0d: got %h want %h", b, fifo_din, exp_d[b]); else passed++;
      checks++; if (req_ready !== 4'b0001) $display("[TB] FAIL single_ready beat %0d: got %b want 0001", b, req_ready); else passed++;
      checks++; if (grant_id !== 2'd0) $display("[TB] FAIL single_grant beat %0d: got %0d want 0", b, grant_id); else passed++;
    end
    step();
    checks++; if (busy !== 1'b0) $display("[TB] FAIL single_done_busy: got %b want 0", busy); else passed++;
    checks++; if (fifo_wr_en !== 1'b0) $display("[TB] FAIL single_done_wr_en: got %b want 0", fifo_wr_en); else passed++;
  endtask

  task automatic test_round_robin();
    int w;
    int r;
    logic [W-1:0] exp_d;
    apply_reset();
    for (int i = 0; i < NR; i++)
      for (int k = 0; k < 3; k++) push_beat(i, 8'(16*i + k), 1'b1);
    for (int c = 0; c < 16; c++) begin
      step();
      if (c % 2 == 0) begin
        checks++; if (fifo_wr_en !== 1'b0) $display("[TB] FAIL rr_idle_wr_en cycle %0d: got %b want 0", c, fifo_wr_en); else passed++;
      end else begin
        w = c / 2;
        r = w % NR;
        exp_d = 8'(16*r + w/NR);
        checks++; if (fifo_wr_en !== 1'b1) $display("[TB] FAIL rr_wr_en cycle %0d: got %b want 1", c, fifo_wr_en); else passed++;
        checks++; if (grant_id !== IW'(r)) $display("[TB] FAIL rr_grant cycle %0d: got %0d want %0d", c, grant_id, r); else passed++;
        checks++; if (fifo_din !== exp_d) $display("[TB] FAIL rr_din cycle %0d: got %h want %h", c, fifo_din, exp_d); else passed++;
      end
    end
  endtask

  task automatic test_burst_cut();
    logic [W-1:0]  exp_d [22];
    logic [IW-1:0] exp_s [22];
    apply_reset();
    for (int k = 0; k < 20; k++) push_beat(1, 8'(8'h40 + k), (k == 19));
    push_beat(2, 8'hA0, 1'b0);
    push_beat(2, 8'hA1, 1'b1);
    for (int j = 0; j < 16; j++) begin exp_d[j] = 8'(8'h40 + j); exp_s[j] = 2'd1; end
    exp_d[16] = 8'hA0; exp_s[16] = 2'd2;
    exp_d[17] = 8'hA1; exp_s[17] = 2'd2;
    for (int j = 0; j < 4; j++) begin exp_d[18+j] = 8'(8'h50 + j); exp_s[18+j] = 2'd1; end
    for (int s = 0; s < 26; s++) begin
      step();
      if (s == 17) begin
        checks++; if (busy !== 1'b0) $display("[TB] FAIL cut_busy after 16 beats: got %b want 0", busy); else passed++;
      end
    end
    checks++; if (log_data.size() != 22) $display("[TB] FAIL cut_count: got %0d want 22", log_data.size()); else passed++;
    for (int j = 0; j < 22; j++) begin
      if (j < log_data.size()) begin
        checks++; if (log_data[j] !== exp_d[j]) $display("[TB] FAIL cut_data %0d: got %h want %h", j, log_data[j], exp_d[j]); else passed++;
        checks++; if (log_src[j] !== exp_s[j]) $display("[TB] FAIL cut_src %0d: got %0d want %0d", j, log_src[j], exp_s[j]); else passed++;
      end
    end
  endtask

  task automatic test_fifo_full();
    logic [W-1:0] exp_d [4];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h44;
    apply_reset();
    for (int k = 0; k < 4; k++) push_beat(0, exp_d[k], (k == 3));
    step();
    step();
    step();
    hold_full = 1'b1;
    for (int s = 0; s < 5; s++) begin
      step();
      checks++; if (fifo_wr_en !== 1'b0) $display("[TB] FAIL full_wr_en stall %0d: got %b want 0", s, fifo_wr_en); else passed++;
      checks++; if (req_ready !== 4'b0000) $display("[TB] FAIL full_ready stall %0d: got %b want 0000", s, req_ready); else passed++;
      checks++; if (busy !== 1'b1) $display("[TB] FAIL full_busy stall %0d: got %b want 1", s, busy); else passed++;
    end
    hold_full = 1'b0;
    step();
    step();
    step();
    checks++; if (busy !== 1'b0) $display("[TB] FAIL full_done_busy: got %b want 0", busy); else passed++;
    checks++; if (log_data.size() != 4) $display("[TB] FAIL full_count: got %0d want 4", log_data.size()); else passed++;
    for (int j = 0; j < 4; j++) begin
      if (j < log_data.size()) begin
        checks++; if (log_data[j] !== exp_d[j]) $display("[TB] FAIL full_data %0d: got %h want %h", j, log_data[j], exp_d[j]); else passed++;
      end
    end
  endtask

  task automatic test_packet_lock();
    apply_reset();
    for (int k = 0; k < 4; k++) push_beat(0, 8'(8'h50 + k), (k == 3));
    push_beat(3, 8'h70, 1'b1);
    step();
    for (int s = 1; s <= 8; s++) begin
      mask = (s >= 3 && s <= 5) ? 4'b0001 : 4'b0000;
      step();
      checks++; if (req_ready[3] !== 1'b0) $display("[TB] FAIL lock_ready3 cycle %0d: got %b want 0", s, req_ready[3]); else passed++;
      if (s >= 3 && s <= 5) begin
        checks++; if (busy !== 1'b1 || grant_id !== 2'd0) $display("[TB] FAIL lock_hold cycle %0d: got busy %b id %0d want busy 1 id 0", s, busy, grant_id); else passed++;
        checks++; if (fifo_wr_en !== 1'b0) $display("[TB] FAIL lock_wr_en cycle %0d: got %b want 0", s, fifo_wr_en); else passed++;
        checks++; if (req_ready !== 4'b0001) $display("[TB] FAIL lock_ready cycle %0d: got %b want 0001", s, req_ready); else passed++;
      end
    end
    step();
    checks++; if (fifo_wr_en !== 1'b1 || grant_id !== 2'd3) $display("[TB] FAIL lock_req3_served: got wr %b id %0d want wr 1 id 3", fifo_wr_en, grant_id); else passed++;
    checks++; if (fifo_din !== 8'h70) $display("[TB] FAIL lock_req3_din: got %h want 70", fifo_din); else passed++;
    checks++; if (log_data.size() != 5) $display("[TB] FAIL lock_count: got %0d want 5", log_data.size()); else passed++;
    if (log_data.size() >= 4) begin
      checks++; if (log_data[3] !== 8'h53) $display("[TB] FAIL lock_last_beat: got %h want 53", log_data[3]); else passed++;
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    push_beat(1, 8'hB1, 1'b1);
    for (int k = 0; k < 4; k++) push_beat(2, 8'(8'hC0 + k), (k == 3));
    step();
    step();
    checks++; if (grant_id !== 2'd1 || fifo_wr_en !== 1'b1) $display("[TB] FAIL areset_pre_grant1: got id %0d wr %b want id 1 wr 1", grant_id, fifo_wr_en); else passed++;
    step();
    step();
    step();
    checks++; if (grant_id !== 2'd2 || busy !== 1'b1 || fifo_wr_en !== 1'b1) $display("[TB] FAIL areset_midburst: got id %0d busy %b wr %b want 2 1 1", grant_id, busy, fifo_wr_en); else passed++;
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL areset_busy: got %b want 0", busy); else passed++;
    checks++; if (fifo_wr_en !== 1'b0) $display("[TB] FAIL areset_wr_en: got %b want 0", fifo_wr_en); else passed++;
    checks++; if (req_ready !== 4'b0000) $display("[TB] FAIL areset_ready: got %b want 0000", req_ready); else passed++;
    checks++; if (fifo_din !== 8'h00) $display("[TB] FAIL areset_din: got %h want 00", fifo_din); else passed++;
    @(negedge clk);
    clear_all();
    push_beat(0, 8'hD0, 1'b1);
    push_beat(2, 8'hC1, 1'b0);
    push_beat(2, 8'hC2, 1'b0);
    push_beat(2, 8'hC3, 1'b1);
    push_beat(3, 8'hE0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    step();
    checks++; if (busy !== 1'b0) $display("[TB] FAIL areset_post_idle: got %b want 0", busy); else passed++;
    step();
    checks++; if (grant_id !== 2'd0 || fifo_wr_en !== 1'b1) $display("[TB] FAIL areset_req0_first: got id %0d wr %b want id 0 wr 1", grant_id, fifo_wr_en); else passed++;
    checks++; if (fifo_din !== 8'hD0) $display("[TB] FAIL areset_req0_din: got %h want D0", fifo_din); else passed++;
  endtask

  initial begin
    rst = 1'b0;
    clear_all();
    test_reset();
    test_single_packet();
    test_round_robin();
    test_burst_cut();
    test_fifo_full();
    test_packet_lock();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
